ks_32bit: RTL and testbench



---
 rtl/ks_32bit.sv | 89 ++++++++
 tb/tb_ks_32bit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ks_32bit.sv
// ks_32bit: 32-bit Kogge-Stone parallel-prefix adder with carry-in.
// Bit-level generate/propagate feed a 5-level prefix tree (spans 1,2,4,8,16);
// the resulting group generates are the carries. Sum and carry vector are
// captured in a single output register stage with synchronous reset.
module ks_32bit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [32:0] s,
   output logic [31:0] c
);

   localparam logic [4:0] SPAN_L1 = 5'd1;
   localparam logic [4:0] SPAN_L2 = 5'd2;
   localparam logic [4:0] SPAN_L3 = 5'd4;
   localparam logic [4:0] SPAN_L4 = 5'd8;
   localparam logic [4:0] SPAN_L5 = 5'd16;

   // One prefix level, generate half. Shifting the vector left by the span
   // aligns node i-span with node i; below the span the shifted value is
   // zero, so those nodes pass their generate through unchanged.
   function automatic logic [31:0] level_g(input logic [31:0] g_in,
                                           input logic [31:0] p_in,
                                           input logic [4:0]  span);
      return g_in | (p_in & (g_in << span));
   endfunction

   // One prefix level, propagate half. Nodes below the span are forced to
   // keep their own propagate by OR-ing in a low mask.
   function automatic logic [31:0] level_p(input logic [31:0] p_in,
                                           input logic [4:0]  span);
      logic [31:0] low_mask;
      low_mask = ~(32'hFFFF_FFFF << span);
      return p_in & ((p_in << span) | low_mask);
   endfunction

   logic [31:0] p_bit;
   logic [31:0] g_l0, p_l0;
   logic [31:0] g_l1, p_l1;
   logic [31:0] g_l2, p_l2;
   logic [31:0] g_l3, p_l3;
   logic [31:0] g_l4, p_l4;
   logic [31:0] g_l5, p_l5;
   logic [31:0] carry;
   logic [31:0] sum_bits;

   // Bit-level terms, with the carry-in folded into the bit-0 generate so
   // that every group generate G[i:0] already accounts for cin.
   always_comb begin
      p_bit   = a ^ b;
      g_l0    = a & b;
      g_l0[0] = (a[0] & b[0]) | (p_bit[0] & cin);
      p_l0    = p_bit;
   end

   // Five Kogge-Stone levels; after the last one g_l5[i] = G[i:0].
   always_comb begin
      g_l1 = level_g(g_l0, p_l0, SPAN_L1);
      p_l1 = level_p(p_l0, SPAN_L1);
      g_l2 = level_g(g_l1, p_l1, SPAN_L2);
      p_l2 = level_p(p_l1, SPAN_L2);
      g_l3 = level_g(g_l2, p_l2, SPAN_L3);
      p_l3 = level_p(p_l2, SPAN_L3);
      g_l4 = level_g(g_l3, p_l3, SPAN_L4);
      p_l4 = level_p(p_l3, SPAN_L4);
      g_l5 = level_g(g_l4, p_l4, SPAN_L5);
      p_l5 = level_p(p_l4, SPAN_L5);
   end

   // Carries and sum bits: bit i takes the carry out of bit i-1, bit 0 takes cin.
   always_comb begin
      carry    = g_l5;
      sum_bits = p_bit ^ {carry[30:0], cin};
   end

   // Output register stage; reset clears both outputs regardless of inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         s <= 33'h0_0000_0000;
         c <= 32'h0000_0000;
      end else begin
         s <= {carry[31], sum_bits};
         c <= carry;
      end
   end

endmodule

// File: tb/tb_ks_32bit.sv
// tb_ks_32bit: directed and randomized self-checking bench for ks_32bit.
// Expected values come from plain 33-bit arithmetic on the operands.
module tb_ks_32bit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a   = 32'h0;
   logic [31:0] b   = 32'h0;
   logic        cin = 1'b0;
   logic [32:0] s;
   logic [31:0] c;

   int checks = 0;
   int errors = 0;

   ks_32bit dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .cin (cin),
      .s   (s),
      .c   (c)
   );

   always #5 clk = ~clk;

   // Reference: sum by ordinary addition, carry vector from the identity
   // carry_into = a ^ b ^ sum, shifted down so bit i is the carry out of bit i.
   function automatic logic [32:0] ref_sum(input logic [31:0] x, input logic [31:0] y,
                                           input logic ci);
      return {1'b0, x} + {1'b0, y} + {32'h0, ci};
   endfunction

   function automatic logic [31:0] ref_carry(input logic [31:0] x, input logic [31:0] y,
                                             input logic ci);
      logic [32:0] sm;
      logic [31:0] cv;
      sm = ref_sum(x, y, ci);
      cv = (x ^ y ^ sm[31:0]) >> 1;
      cv[31] = sm[32];
      return cv;
   endfunction

   task automatic check_out(input string tag, input logic [32:0] exp_s, input logic [31:0] exp_c);
      checks++;
      assert (s === exp_s) else begin
         errors++;
         $error("FAIL %s s observed %h expected %h", tag, s, exp_s);
      end
      checks++;
      assert (c === exp_c) else begin
         errors++;
         $error("FAIL %s c observed %h expected %h", tag, c, exp_c);
      end
   endtask

   // Apply one operation, clock it, and check the registered result.
   task automatic step(input string tag, input logic r, input logic [31:0] x,
                       input logic [31:0] y, input logic ci);
      rst = r;
      a   = x;
      b   = y;
      cin = ci;
      @(posedge clk);
      #1;
      if (r) check_out(tag, 33'h0, 32'h0);
      else   check_out(tag, ref_sum(x, y, ci), ref_carry(x, y, ci));
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rc, rr;

      // Reset with all-ones inputs, then release.
      step("rst0", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      step("rst1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_out("rst_release", 33'h1_FFFF_FFFF, 32'hFFFF_FFFF);

      // Directed adds, with hard constants for the listed cases.
      step("zero", 1'b0, 32'h0, 32'h0, 1'b0);
      check_out("zero_k", 33'h0, 32'h0);
      step("add1", 1'b0, 32'h631F_F211, 32'h1235_6312, 1'b0);
      check_out("add1_k", 33'h0_7555_5523, ref_carry(32'h631F_F211, 32'h1235_6312, 1'b0));
      step("add2", 1'b0, 32'h0FE0_2306, 32'hFAF2_FCFF, 1'b0);
      check_out("add2_k", 33'h1_0AD3_2005, ref_carry(32'h0FE0_2306, 32'hFAF2_FCFF, 1'b0));
      step("add3", 1'b0, 32'h0FE9_2C06, 32'hF098_AC32, 1'b0);
      check_out("add3_k", 33'h1_0081_D838, ref_carry(32'h0FE9_2C06, 32'hF098_AC32, 1'b0));
      step("max_c0", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check_out("max_c0_k", 33'h1_FFFF_FFFE, 32'hFFFF_FFFF);
      step("max_c1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      check_out("max_c1_k", 33'h1_FFFF_FFFF, 32'hFFFF_FFFF);
      step("prop_c1", 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
      check_out("prop_c1_k", 33'h1_0000_0000, 32'hFFFF_FFFF);
      step("prop_c0", 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      check_out("prop_c0_k", 33'h0_FFFF_FFFF, 32'h0);
      step("cin_only", 1'b0, 32'h0, 32'h0, 1'b1);
      check_out("cin_only_k", 33'h1, 32'h0);
      step("cin_one", 1'b0, 32'h1, 32'h0, 1'b1);
      check_out("cin_one_k", 33'h2, 32'h1);

      // Inputs changing between edges must not disturb the held outputs.
      a = 32'h1234_5678;
      b = 32'h9ABC_DEF0;
      #3;
      check_out("hold", 33'h2, 32'h1);

      // Random back-to-back stream.
      for (int i = 0; i < 10000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(1, 0));
         step("rand", 1'b0, ra, rb, rc);
      end

      // Random stream with random reset pulses.
      for (int i = 0; i < 2000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(1, 0));
         rr = ($urandom_range(7, 0) == 0);
         step(rr ? "rand_rst" : "rand_post", rr, ra, rb, rc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
